washer_display_scan: RTL and testbench
======================================

Name: washer_display_scan

Overview:
- Consumer end of the washer controller's time display: takes the controller's remaining-total and remaining-phase times as binary, converts each to BCD, and drives a 4-digit multiplexed active-low seven-segment display.
- Digits 3..2 show total_time, digits 1..0 show current_time, with the dp on digit 2 as separator.
- Sits between the washer controller and the board display pins, in the same 100 MHz clock domain.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- SCAN_HZ, 1000, digit-advance rate (full refresh = SCAN_HZ/4).
- BLINK_HZ, 1, blink rate used while `blink` is high.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- upd_valid  in  1  one-cycle strobe: capture total_time/current_time.
- upd_ready  out  1  high when a new update can be accepted.
- total_time  in  7  remaining total minutes, binary.
- current_time  in  7  remaining phase minutes, binary.
- blank  in  1  power off; all digits dark.
- blink  in  1  paused; display flashes at BLINK_HZ.
- done  out  1  one-cycle pulse when new values reach the display registers.
- an  out  4  digit enables, active-low, one-hot.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset (async, immediate) values:
  - an=4'b1111, seg=7'h7F, dp=1, upd_ready=1, done=0.
  - Scan index=0, prescaler=0, blink phase=on.
  - Display BCD registers=0; converter in IDLE.
- Converter FSM, states IDLE, CONV, COMMIT:
  - IDLE: upd_ready=1. upd_valid=1 latches both inputs → CONV, upd_ready=0 from the next cycle.
  - Saturation at capture: any value >99 is replaced by 99.
  - CONV: shift-add-3 double-dabble, one bit per cycle, both values in parallel, 7 cycles (MSB first). Before each shift, add 3 to every nibble ≥5.
  - COMMIT: one cycle. Both BCD results are written to the display registers together, done=1, then → IDLE.
  - Latency: upd_valid on cycle N → display registers and done on cycle N+8. upd_ready is high again on N+9.
  - upd_valid while upd_ready=0 is ignored; no queuing, no corruption of the in-flight conversion.
  - Reset mid-conversion: aborts the conversion, display registers return to 0, and no done pulse is issued.
- Scan:
  - Prescaler counts 0..CLK_HZ/SCAN_HZ-1. On wrap it emits a tick, and the scan index advances 0→1→2→3→0.
  - an has a single 0 at bit [index], registered. seg and dp change in the same cycle as an.
  - Digit map:
    - 0 = current ones.
    - 1 = current tens.
    - 2 = total ones, with dp=0.
    - 3 = total tens.
    - dp=1 on all other digits.
  - Leading-zero blanking: a tens digit equal to 0 gives seg=7'h7F. Ones digits always show, so 0 displays as "0".
  - Decode 0-9 to standard patterns; e.g. 0=7'h40, 1=7'h79, 5=7'h12, 9=7'h10. Non-BCD values never occur.
- Blank/blink:
  - blank=1 forces an=4'b1111, seg=7'h7F, dp=1. Conversion and scanning continue internally. blank has priority over blink.
  - blink=1: a half-period counter (CLK_HZ/(2*BLINK_HZ) cycles) toggles the phase. Off phase behaves as blank.
  - blink=0: phase is forced on and the counter is cleared.
- Display registers hold their value indefinitely between updates.

Decomposition:
- Shared package washer_pkg:
  - seven-segment constant table SEG_DIGIT[0:9].
  - SEG_OFF=7'h7F.
  - time width TIME_W=7.
  - TIME_MAX=99.
- Natural sub-module: bin2bcd_seq, a 7-bit sequential double-dabble with start/done. Instantiated twice in the top, which holds the FSM, scan and blink logic.

Test Plan (bench uses CLK_HZ=8, SCAN_HZ=2 → tick every 4 cycles; BLINK_HZ=1 → blink phase 4 cycles):
- Reset asserted mid-run → an=1111, seg=7F, dp=1, upd_ready=1 within the same cycle. After release with blank=0, digit 0 shows "0" (seg=40) and digit 3 is blank.
- upd_valid with total=45, current=12 → done exactly 8 cycles later. Over one full scan, digits 3..0 show seg 19,12(dp=0),79,24.
- total=120, current=5 → digits 3..2 show 99. Digit 1 blank (7F), digit 0 seg=12.
- Second upd_valid 3 cycles after the first (values 77,77) → ignored, no extra done, display shows first values. A new update is accepted once upd_ready returns.
- blank=1 → an=1111 continuously. Then blank=0, blink=1 → display alternates 4 cycles on / 4 cycles off. blink=0 → steady.
- Reset asserted during CONV cycle 4 → no done pulse, display reads " 0. 0" after release.

Source files
------------

// File: rtl/washer_pkg.sv
// Shared constants for the washer time display: seven-segment patterns,
// time width/limit and the update-converter state encoding.
package washer_pkg;

   localparam int unsigned      TIME_W   = 7;
   localparam logic [TIME_W-1:0] TIME_MAX = 7'd99;
   localparam logic [6:0]       SEG_OFF  = 7'h7F;

   // {g,f,e,d,c,b,a}, active-low, index 0 leftmost
   localparam logic [0:9][6:0] SEG_DIGIT = {
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONV,
      ST_COMMIT
   } conv_state_t;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      if (d > 4'd9) return SEG_OFF;
      return SEG_DIGIT[d];
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to two-digit BCD converter, one bit per cycle.
// Inputs are expected to be already limited to 0..99.
module bin2bcd_seq
   import washer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [TIME_W-1:0] bin,
   output logic [7:0]        bcd,
   output logic              done
);

   logic [TIME_W-2:0] sr;
   logic [2:0]        cnt;

   function automatic logic [7:0] dabble(input logic [7:0] v, input logic b);
      logic [3:0] hi;
      logic [3:0] lo;
      lo = v[3:0];
      hi = v[7:4];
      if (lo >= 4'd5) lo = lo + 4'd3;
      if (hi >= 4'd5) hi = hi + 4'd3;
      return {hi[2:0], lo, b};
   endfunction

   // The MSB shift is folded into the load: add-3 on an all-zero register
   // is a no-op, so the remaining TIME_W-1 bits take one cycle each.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr   <= '0;
         cnt  <= '0;
         bcd  <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            bcd <= {7'd0, bin[TIME_W-1]};
            sr  <= bin[TIME_W-2:0];
            cnt <= 3'(TIME_W - 1);
         end else if (cnt != 3'd0) begin
            bcd <= dabble(bcd, sr[TIME_W-2]);
            sr  <= {sr[TIME_W-3:0], 1'b0};
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) done <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/washer_display_scan.sv
// Washer time display: captures total/phase minutes, converts to BCD and
// scans a 4-digit active-low seven-segment display with blank and blink.
module washer_display_scan
   import washer_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 100_000_000,
   parameter int unsigned SCAN_HZ  = 1000,
   parameter int unsigned BLINK_HZ = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              upd_valid,
   output logic              upd_ready,
   input  logic [TIME_W-1:0] total_time,
   input  logic [TIME_W-1:0] current_time,
   input  logic              blank,
   input  logic              blink,
   output logic              done,
   output logic [3:0]        an,
   output logic [6:0]        seg,
   output logic              dp
);

   localparam int unsigned SCAN_DIV   = CLK_HZ / SCAN_HZ;
   localparam int unsigned PRE_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
   localparam int unsigned BLK_W      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   conv_state_t       state, state_nxt;
   logic              start;
   logic [TIME_W-1:0] tot_sat, cur_sat;
   logic [7:0]        tot_bcd, cur_bcd;
   logic              tot_done, cur_done;
   logic [7:0]        disp_tot, disp_cur;

   assign tot_sat = (total_time   > TIME_MAX) ? TIME_MAX : total_time;
   assign cur_sat = (current_time > TIME_MAX) ? TIME_MAX : current_time;

   bin2bcd_seq u_tot (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bin   (tot_sat),
      .bcd   (tot_bcd),
      .done  (tot_done)
   );

   bin2bcd_seq u_cur (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bin   (cur_sat),
      .bcd   (cur_bcd),
      .done  (cur_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      upd_ready = 1'b0;
      done      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            upd_ready = 1'b1;
            if (upd_valid) begin
               start     = 1'b1;
               state_nxt = ST_CONV;
            end
         end
         ST_CONV:   if (tot_done && cur_done) state_nxt = ST_COMMIT;
         ST_COMMIT: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Loaded on entry to COMMIT so the new values are in place while done is high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp_tot <= '0;
         disp_cur <= '0;
      end else if (state == ST_CONV && tot_done && cur_done) begin
         disp_tot <= tot_bcd;
         disp_cur <= cur_bcd;
      end
   end

   logic [PRE_W-1:0] pre;
   logic             tick;
   logic [1:0]       idx;

   assign tick = (pre == PRE_W'(SCAN_DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre <= '0;
         idx <= '0;
      end else begin
         pre <= tick ? '0 : pre + PRE_W'(1);
         if (tick) idx <= idx + 2'd1;
      end
   end

   logic [BLK_W-1:0] bcnt;
   logic             phase;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bcnt  <= '0;
         phase <= 1'b1;
      end else if (!blink) begin
         bcnt  <= '0;
         phase <= 1'b1;
      end else if (bcnt == BLK_W'(BLINK_HALF - 1)) begin
         bcnt  <= '0;
         phase <= ~phase;
      end else begin
         bcnt <= bcnt + BLK_W'(1);
      end
   end

   logic [3:0] digit;
   logic       lz_blank;
   logic [3:0] an_nxt;
   logic [6:0] seg_nxt;
   logic       dp_nxt;

   always_comb begin
      digit    = '0;
      lz_blank = 1'b0;
      dp_nxt   = 1'b1;
      unique case (idx)
         2'd0: digit = disp_cur[3:0];
         2'd1: begin
            digit    = disp_cur[7:4];
            lz_blank = (digit == 4'd0);
         end
         2'd2: begin
            digit  = disp_tot[3:0];
            dp_nxt = 1'b0;
         end
         default: begin
            digit    = disp_tot[7:4];
            lz_blank = (digit == 4'd0);
         end
      endcase
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = lz_blank ? SEG_OFF : seg_decode(digit);
      if (blank || !phase) begin
         an_nxt  = '1;
         seg_nxt = SEG_OFF;
         dp_nxt  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an  <= '1;
         seg <= SEG_OFF;
         dp  <= 1'b1;
      end else begin
         an  <= an_nxt;
         seg <= seg_nxt;
         dp  <= dp_nxt;
      end
   end

endmodule

// File: tb/tb_washer_display_scan.sv
// Scoreboard bench for washer_display_scan: expected done cycles and scanned
// digits are queued by the stimulus and checked by an independent monitor.
module tb_washer_display_scan;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       upd_valid = 1'b0;
   logic       upd_ready;
   logic [6:0] total_time = '0;
   logic [6:0] current_time = '0;
   logic       blank = 1'b0;
   logic       blink = 1'b0;
   logic       done;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   washer_display_scan #(
      .CLK_HZ   (8),
      .SCAN_HZ  (2),
      .BLINK_HZ (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .upd_valid    (upd_valid),
      .upd_ready    (upd_ready),
      .total_time   (total_time),
      .current_time (current_time),
      .blank        (blank),
      .blink        (blink),
      .done         (done),
      .an           (an),
      .seg          (seg),
      .dp           (dp)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } disp_t;

   int    n_tests = 0;
   int    n_fail  = 0;
   int    done_q[$];
   disp_t scan_q[$];

   task automatic check(input string name, input int actual, input int expected);
      n_tests++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: done pulses and freshly presented digits are popped and compared.
   logic [3:0] mon_prev_an = 4'hF;
   bit         mon_scanning = 1'b0;
   int         mon_exp_cyc;
   disp_t      mon_d;

   initial begin
      forever begin
         @(negedge clk);
         if (done) begin
            if (done_q.size() == 0) begin
               check("spurious_done", 1, 0);
            end else begin
               mon_exp_cyc = done_q.pop_front();
               check("done_cycle", cyc, mon_exp_cyc);
            end
         end
         if (an != mon_prev_an) begin
            if (!mon_scanning && scan_q.size() != 0 && an == 4'hE) mon_scanning = 1'b1;
            if (mon_scanning) begin
               mon_d = scan_q.pop_front();
               check("scan_an",  int'(an),  int'(mon_d.an));
               check("scan_seg", int'(seg), int'(mon_d.seg));
               check("scan_dp",  int'(dp),  int'(mon_d.dp));
               if (scan_q.size() == 0) mon_scanning = 1'b0;
            end
         end
         mon_prev_an = an;
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [6:0] t, input logic [6:0] c, input bit accepted);
      total_time   = t;
      current_time = c;
      upd_valid    = 1'b1;
      if (accepted) done_q.push_back(cyc + 8);
      cycles(1);
      upd_valid = 1'b0;
   endtask

   task automatic wait_ready(input int budget);
      int k;
      k = 0;
      while (!upd_ready && k < budget) begin
         cycles(1);
         k++;
      end
      check("upd_ready_return", int'(upd_ready), 1);
   endtask

   task automatic expect_digits(input logic [6:0] s3, input logic [6:0] s2,
                                input logic [6:0] s1, input logic [6:0] s0);
      int k;
      scan_q.push_back(disp_t'{4'hE, s0, 1'b1});
      scan_q.push_back(disp_t'{4'hD, s1, 1'b1});
      scan_q.push_back(disp_t'{4'hB, s2, 1'b0});
      scan_q.push_back(disp_t'{4'h7, s3, 1'b1});
      k = 0;
      while (scan_q.size() != 0 && k < 48) begin
         cycles(1);
         k++;
      end
      check("scan_complete", scan_q.size(), 0);
      scan_q.delete();
   endtask

   task automatic check_reset_outputs();
      check("rst_an",        int'(an),        'hF);
      check("rst_seg",       int'(seg),       'h7F);
      check("rst_dp",        int'(dp),        1);
      check("rst_upd_ready", int'(upd_ready), 1);
      check("rst_done",      int'(done),      0);
   endtask

   initial begin
      #1 reset = 1'b1;
      #1 check_reset_outputs();
      cycles(2);
      reset = 1'b0;
      expect_digits(7'h7F, 7'h40, 7'h7F, 7'h40);

      // 45 / 12: latency and ready handshake
      send(7'd45, 7'd12, 1'b1);
      check("ready_low_after_capture", int'(upd_ready), 0);
      cycles(7);
      check("ready_low_in_commit", int'(upd_ready), 0);
      cycles(1);
      check("ready_high_after_commit", int'(upd_ready), 1);
      expect_digits(7'h19, 7'h12, 7'h79, 7'h24);

      // asynchronous reset mid-run
      cycles(3);
      #2 reset = 1'b1;
      #2 check_reset_outputs();
      cycles(2);
      reset = 1'b0;
      expect_digits(7'h7F, 7'h40, 7'h7F, 7'h40);

      // saturation, and an update while busy is dropped
      send(7'd120, 7'd5, 1'b1);
      cycles(2);
      check("busy_ready", int'(upd_ready), 0);
      send(7'd77, 7'd77, 1'b0);
      wait_ready(20);
      expect_digits(7'h10, 7'h10, 7'h7F, 7'h12);

      send(7'd7, 7'd60, 1'b1);
      cycles(1);
      wait_ready(20);
      expect_digits(7'h7F, 7'h78, 7'h02, 7'h40);

      blank = 1'b1;
      cycles(1);
      for (int k = 0; k < 12; k++) begin
         check("blank_an", int'(an), 'hF);
         cycles(1);
      end

      blank = 1'b0;
      blink = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         cycles(1);
         check("blink_dark", int'(an == 4'hF), ((k - 1) / 4) % 2);
      end
      blink = 1'b0;
      cycles(2);
      for (int k = 0; k < 8; k++) begin
         check("steady_lit", int'(an == 4'hF), 0);
         cycles(1);
      end

      // reset during the fourth conversion cycle: no done, display zeroed
      send(7'd33, 7'd44, 1'b0);
      cycles(3);
      reset = 1'b1;
      #1 check("abort_done", int'(done), 0);
      cycles(2);
      reset = 1'b0;
      cycles(12);
      expect_digits(7'h7F, 7'h40, 7'h7F, 7'h40);

      check("done_queue_empty", done_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
      $fatal(1, "timeout");
   end

endmodule
